sopc: RTL and testbench

//   Minimal RISC-V system-on-programmable-chip: single-cycle RV32I core, instruction ROM, data RAM.
//   Top-level target of the CPU simulation bench; only clock and reset cross the boundary.

---
 rtl/sopc.sv | 184 ++++++++++++++++++
 tb/tb_sopc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sopc.sv
// Minimal RV32I system: single-cycle core, combinational-read instruction ROM and data RAM.
// Architectural state (pc, regs, rom, ram) is reached hierarchically by the loader and the bench.
module sopc #(
    parameter ROM_FILE = "inst_rom.data",
    parameter int ROM_DEPTH = 1024,
    parameter int RAM_DEPTH = 1024
) (
    input logic clk,
    input logic rst
);
    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    // The image named by ROM_FILE is placed into rom by the simulation loader.
    localparam int unused_rom_file_bits = $bits(ROM_FILE);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] rom [ROM_DEPTH];
    logic [31:0] ram [RAM_DEPTH];
    logic [31:0] regs [32];
    logic [31:0] pc;

    logic [31:0] inst;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst   = rom[pc[ROM_AW+1:2]];
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'd0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = alt ? a - b : a + b;
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Data memory access: word-aligned, lanes chosen by the low address bits.
    logic [31:0] mem_addr, ld_word, ld_shift;
    logic [15:0] ld_half;
    logic [RAM_AW-1:0] ram_idx;
    logic unused_addr_hi;

    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign ram_idx  = mem_addr[RAM_AW+1:2];
    assign ld_word  = ram[ram_idx];
    assign ld_shift = ld_word >> {mem_addr[1:0], 3'b000};
    assign ld_half  = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
    assign unused_addr_hi = ^mem_addr[31:RAM_AW+2];

    logic [31:0] next_pc, wb_data, st_data;
    logic        wb_en, st_en, taken;
    logic [3:0]  st_be;

    always_comb begin
        next_pc = pc + 32'd4;
        wb_en   = 1'b0;
        wb_data = 32'd0;
        st_en   = 1'b0;
        st_be   = 4'b0000;
        st_data = 32'd0;
        taken   = 1'b0;
        case (opcode)
            OP_LUI: begin
                wb_en = 1'b1; wb_data = imm_u;
            end
            OP_AUIPC: begin
                wb_en = 1'b1; wb_data = pc + imm_u;
            end
            OP_JAL: begin
                wb_en = 1'b1; wb_data = pc + 32'd4; next_pc = pc + imm_j;
            end
            OP_JALR: if (funct3 == 3'd0) begin
                wb_en = 1'b1; wb_data = pc + 32'd4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  taken = rs1_val == rs2_val;
                    3'b001:  taken = rs1_val != rs2_val;
                    3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
                    3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
                    3'b110:  taken = rs1_val < rs2_val;
                    3'b111:  taken = rs1_val >= rs2_val;
                    default: taken = 1'b0;
                endcase
                if (taken) next_pc = pc + imm_b;
            end
            OP_LOAD: begin
                wb_en = 1'b1;
                case (funct3)
                    3'b000:  wb_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
                    3'b001:  wb_data = {{16{ld_half[15]}}, ld_half};
                    3'b010:  wb_data = ld_word;
                    3'b100:  wb_data = {24'd0, ld_shift[7:0]};
                    3'b101:  wb_data = {16'd0, ld_half};
                    default: wb_en = 1'b0;
                endcase
            end
            OP_STORE: begin
                st_en = 1'b1;
                case (funct3)
                    3'b000: begin
                        st_be = 4'b0001 << mem_addr[1:0]; st_data = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        st_be = mem_addr[1] ? 4'b1100 : 4'b0011; st_data = {2{rs2_val[15:0]}};
                    end
                    3'b010: begin
                        st_be = 4'b1111; st_data = rs2_val;
                    end
                    default: st_en = 1'b0;
                endcase
            end
            OP_IMM: begin
                // Shift-immediates must carry a legal funct7; everything else is a NOP.
                if ((funct3 == 3'd1 && funct7 == 7'h00) ||
                    (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
                    (funct3 != 3'd1 && funct3 != 3'd5)) begin
                    wb_en = 1'b1;
                    wb_data = alu(funct3, funct3 == 3'd5 && inst[30], rs1_val, imm_i);
                end
            end
            OP_REG: begin
                if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
                    wb_en = 1'b1;
                    wb_data = alu(funct3, inst[30], rs1_val, rs2_val);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
        end
    end

    // RAM is not reset; a store coinciding with reset is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst && st_en) begin
            for (int b = 0; b < 4; b++)
                if (st_be[b]) ram[ram_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_sopc.sv
// Directed bench for sopc: loads small programs into rom, runs them and inspects pc, regs and ram.
module tb_sopc;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    sopc dut (.clk(clk), .rst(rst));

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic load(input logic [31:0] prog[$]);
        for (int i = 0; i < 1024; i++) dut.rom[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.rom[i] = prog[i];
        for (int i = 0; i < 1024; i++) dut.ram[i] = 32'd0;
    endtask

    task automatic start(input logic [31:0] prog[$]);
        rst = 1'b1;
        load(prog);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string name, input int r, input logic [31:0] exp);
        checks++;
        if (dut.regs[r] !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, dut.regs[r], exp);
        end
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        checks++;
        if (dut.pc !== exp) begin
            failures++;
            $display("FAIL %s: pc got %h expected %h", name, dut.pc, exp);
        end
    endtask

    task automatic test_reset();
        logic [31:0] prog[$];
        bit nz;
        rst = 1'b1;
        prog = {};
        load(prog);
        for (int t = 0; t < 3; t++) begin
            #60;
            nz = 1'b0;
            for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'd0) nz = 1'b1;
            checks++;
            if (nz) begin failures++; $display("FAIL reset_regs: nonzero register during reset, expected all 0"); end
            chk_pc("reset_pc", 32'd0);
        end
        #15;
        rst = 1'b0;
        run(1);
        chk_pc("first_fetch", 32'd4);
    endtask

    task automatic test_dependency();
        start('{enc_i(12'h011, 0, 6, 1, 7'b0010011), enc_i(12'h220, 1, 6, 2, 7'b0010011),
                enc_i(-1, 2, 0, 3, 7'b0010011)});
        run(3);
        chk_reg("ori_x1", 1, 32'h0000_0011);
        chk_reg("ori_x2", 2, 32'h0000_0231);
        chk_reg("addi_x3", 3, 32'h0000_0230);
        chk_pc("dep_pc", 32'd12);
    endtask

    task automatic test_shift_arith();
        start('{enc_u(20'h80000, 1, 7'b0110111), enc_i(12'h404, 1, 5, 2, 7'b0010011),
                enc_i(12'h004, 1, 5, 3, 7'b0010011), enc_r(7'h20, 1, 0, 0, 4),
                enc_r(7'h00, 1, 0, 3, 5)});
        run(5);
        chk_reg("lui_x1", 1, 32'h8000_0000);
        chk_reg("srai_x2", 2, 32'hF800_0000);
        chk_reg("srli_x3", 3, 32'h0800_0000);
        chk_reg("sub_x4", 4, 32'h8000_0000);
        chk_reg("sltu_x5", 5, 32'd1);
    endtask

    task automatic test_memory();
        start('{enc_i(-1, 0, 0, 1, 7'b0010011), enc_s(8, 1, 0, 2), enc_s(9, 0, 0, 0),
                enc_i(8, 0, 2, 2, 7'b0000011), enc_i(8, 0, 0, 3, 7'b0000011),
                enc_i(10, 0, 5, 4, 7'b0000011)});
        run(6);
        checks++;
        if (dut.ram[2] !== 32'hFFFF_00FF) begin
            failures++; $display("FAIL ram2: got %h expected ffff00ff", dut.ram[2]);
        end
        chk_reg("lw_x2", 2, 32'hFFFF_00FF);
        chk_reg("lb_x3", 3, 32'hFFFF_FFFF);
        chk_reg("lhu_x4", 4, 32'h0000_FFFF);
    endtask

    task automatic test_loop();
        start('{enc_i(3, 0, 0, 1, 7'b0010011), enc_i(-1, 1, 0, 1, 7'b0010011),
                enc_b(-4, 0, 1, 1), enc_j(8, 5)});
        run(7);
        chk_pc("loop_exit_pc", 32'd12);
        run(1);
        chk_reg("loop_x1", 1, 32'd0);
        chk_reg("jal_x5", 5, 32'd16);
        chk_pc("jal_pc", 32'd20);
    endtask

    task automatic test_branch_jalr();
        start('{enc_i(-1, 0, 0, 1, 7'b0010011), enc_i(1, 0, 0, 2, 7'b0010011),
                enc_b(8, 2, 1, 4), enc_i(1, 0, 0, 3, 7'b0010011),
                enc_b(8, 2, 1, 6), enc_i(7, 0, 0, 4, 7'b0010011),
                enc_u(0, 6, 7'b0010111), enc_i(13, 6, 0, 7, 7'b1100111),
                enc_i(1, 0, 0, 8, 7'b0010011)});
        run(7);
        chk_reg("blt_skip_x3", 3, 32'd0);
        chk_reg("bltu_fall_x4", 4, 32'd7);
        chk_reg("auipc_x6", 6, 32'd24);
        chk_reg("jalr_link_x7", 7, 32'd32);
        chk_reg("jalr_skip_x8", 8, 32'd0);
        chk_pc("jalr_pc", 32'd36);
    endtask

    task automatic test_illegal_and_async_reset();
        start('{enc_i(5, 0, 0, 0, 7'b0010011), 32'hFFFF_FFFF});
        run(1);
        chk_reg("x0_stays_0", 0, 32'd0);
        chk_pc("nop_pc1", 32'd4);
        run(1);
        chk_pc("illegal_pc", 32'd8);
        chk_reg("illegal_x1", 1, 32'd0);
        #5 rst = 1'b1;
        #1 chk_pc("async_reset_pc", 32'd0);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_reset_store();
        start('{enc_i(-1, 0, 0, 1, 7'b0010011), enc_s(0, 1, 0, 2)});
        run(1);
        chk_reg("pre_store_x1", 1, 32'hFFFF_FFFF);
        #4 rst = 1'b1;
        run(1);
        checks++;
        if (dut.ram[0] !== 32'd0) begin
            failures++; $display("FAIL store_suppressed: ram0 got %h expected 00000000", dut.ram[0]);
        end
        chk_reg("reset_x1", 1, 32'd0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dependency();
        test_shift_arith();
        test_memory();
        test_loop();
        test_branch_jalr();
        test_illegal_and_async_reset();
        test_reset_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
